// File: rtl/mod_decoded_counter_encoder.sv
// Registers a decoded counter's one-hot vector, encodes it to a binary index and flags end-of-range shifts.
// Define MOD_DECODED_COUNTER_ENCODER_CHECK_EN to build the shadow counter and sticky divergence error.
module mod_decoded_counter_encoder #(
  parameter int SIZE = 8,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             update,
  input  logic             operation,
  input  logic [SIZE-1:0]  onehot_in,
  input  logic             clear_error,
  output logic [IDX_W-1:0] index_out,
  output logic             index_valid,
  output logic             overflow,
  output logic             underflow,
  output logic             error
);

  // Returns {valid, position}; position is forced to 0 unless exactly one bit is set.
  function automatic logic [IDX_W:0] encode(input logic [SIZE-1:0] vec);
    int unsigned      ones;
    logic [IDX_W-1:0] pos;
    ones = 0;
    pos  = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (vec[i]) begin
        ones = ones + 1;
        pos  = IDX_W'(i);
      end
    end
    if (ones == 1) begin
      return {1'b1, pos};
    end else begin
      return {1'b0, {IDX_W{1'b0}}};
    end
  endfunction

  logic [IDX_W:0]   enc;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_idx;

  assign enc       = encode(onehot_in);
  assign enc_valid = enc[IDX_W];
  assign enc_idx   = enc[IDX_W-1:0];

  // Encode path and range pulses, one cycle behind the inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      index_out   <= '0;
      index_valid <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      index_out   <= enc_idx;
      index_valid <= enc_valid;
      overflow    <= update & operation & onehot_in[SIZE-1];
      underflow   <= update & ~operation & onehot_in[0];
    end
  end

`ifdef MOD_DECODED_COUNTER_ENCODER_CHECK_EN
  typedef enum logic [1:0] {
    TRACK = 2'd0,
    DEAD  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] shadow_idx;
  logic             shadow_live;
  logic [SIZE-1:0]  expected;
  logic [IDX_W-1:0] base_idx;
  logic             base_live;
  logic [IDX_W-1:0] next_idx;
  logic             next_live;
  logic             resync_ok;

  assign expected  = shadow_live ? (SIZE'(1) << shadow_idx) : {SIZE{1'b0}};
  assign resync_ok = enc_valid | (onehot_in == {SIZE{1'b0}});

  // Shadow next state: resync first (if requested), then apply this cycle's update.
  always_comb begin
    base_idx  = shadow_idx;
    base_live = shadow_live;
    if (clear_error && enc_valid) begin
      base_idx  = enc_idx;
      base_live = 1'b1;
    end else if (clear_error && (onehot_in == {SIZE{1'b0}})) begin
      base_live = 1'b0;
    end else begin
      base_live = shadow_live;
    end
    next_idx  = base_idx;
    next_live = base_live;
    if (update && base_live) begin
      if (operation) begin
        if (base_idx == IDX_W'(SIZE - 1)) next_live = 1'b0;
        else                               next_idx  = base_idx + IDX_W'(1);
      end else begin
        if (base_idx == IDX_W'(0)) next_live = 1'b0;
        else                        next_idx  = base_idx - IDX_W'(1);
      end
    end else begin
      next_idx = base_idx;
    end
  end

  // Shadow registers and tracking FSM; a mismatch is judged against the pre-update shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= TRACK;
      shadow_idx  <= '0;
      shadow_live <= 1'b1;
      error       <= 1'b0;
    end else begin
      shadow_idx  <= next_idx;
      shadow_live <= next_live;
      if (clear_error) begin
        if (resync_ok) begin
          state <= next_live ? TRACK : DEAD;
          error <= 1'b0;
        end else begin
          state <= ERROR;
          error <= 1'b1;
        end
      end else begin
        case (state)
          TRACK: begin
            if (onehot_in != expected) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (!next_live) begin
              state <= DEAD;
            end else begin
              state <= TRACK;
            end
          end
          DEAD: begin
            if (onehot_in != {SIZE{1'b0}}) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DEAD;
            end
          end
          ERROR: begin
            state <= ERROR;
            error <= 1'b1;
          end
          default: begin
            state <= ERROR;
            error <= 1'b1;
          end
        endcase
      end
    end
  end
`else
  logic unused_clear_error;

  assign unused_clear_error = clear_error;
  assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_mod_decoded_counter_encoder.sv
// Randomized and directed bench for mod_decoded_counter_encoder (SIZE=8) against a behavioural model.
module tb_mod_decoded_counter_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       update = 1'b0;
  logic       operation = 1'b0;
  logic [7:0] onehot_in = 8'h01;
  logic       clear_error = 1'b0;
  logic [2:0] index_out;
  logic       index_valid;
  logic       overflow;
  logic       underflow;
  logic       error;

  int n_assert = 0;
  int n_fail = 0;

  // Behavioural model: shadow position, alive flag, sticky error.
  int m_idx = 0;
  bit m_live = 1'b1;
  bit m_err = 1'b0;

  mod_decoded_counter_encoder #(.SIZE(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .update     (update),
    .operation  (operation),
    .onehot_in  (onehot_in),
    .clear_error(clear_error),
    .index_out  (index_out),
    .index_valid(index_valid),
    .overflow   (overflow),
    .underflow  (underflow),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check all outputs after the edge.
  task automatic step(input bit rst, input bit upd, input bit op, input logic [7:0] oh, input bit clr);
    bit   one_hot;
    int   pos;
    int   e_idx;
    bit   e_val, e_ovf, e_unf, e_err;
    logic [7:0] want;
    reset = rst; update = upd; operation = op; onehot_in = oh; clear_error = clr;
    one_hot = ($countones(oh) == 1);
    pos     = one_hot ? $clog2(oh) : 0;
    if (rst) begin
      e_idx = 0; e_val = 0; e_ovf = 0; e_unf = 0;
      m_idx = 0; m_live = 1; m_err = 0;
    end else begin
      e_idx = pos; e_val = one_hot;
      e_ovf = upd & op & oh[7];
      e_unf = upd & ~op & oh[0];
      want  = m_live ? (8'h01 << m_idx) : 8'h00;
      if (clr) begin
        if (one_hot)          begin m_idx = pos; m_live = 1; m_err = 0; end
        else if (oh == 8'h00) begin m_live = 0; m_err = 0; end
        else                  m_err = 1;
      end else if (oh != want) begin
        m_err = 1;
      end
      if (upd && m_live) begin
        if (op) begin
          if (m_idx == 7) m_live = 0; else m_idx = m_idx + 1;
        end else begin
          if (m_idx == 0) m_live = 0; else m_idx = m_idx - 1;
        end
      end
    end
`ifdef MOD_DECODED_COUNTER_ENCODER_CHECK_EN
    e_err = m_err;
`else
    e_err = 1'b0;
`endif
    @(posedge clock);
    #1;
    chk("index_out", 32'(index_out), 32'(e_idx));
    chk("index_valid", 32'(index_valid), 32'(e_val));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("underflow", 32'(underflow), 32'(e_unf));
    chk("error", 32'(error), 32'(e_err));
  endtask

  initial begin
    logic [7:0] cnt;
    logic [7:0] oh;
    bit r, u, o, c;

    // Reset, then hold 8'h01.
    step(1, 0, 0, 8'h01, 0);
    step(1, 0, 0, 8'h01, 0);
    step(0, 0, 0, 8'h01, 0);
    step(0, 0, 0, 8'h01, 0);

    // INCR sweep 01..80, then overflow into the dead state and an extra DECR.
    for (int k = 0; k < 7; k++) step(0, 1, 1, 8'h01 << k, 0);
    step(0, 0, 0, 8'h80, 0);
    step(0, 1, 1, 8'h80, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    // Underflow from position 0.
    step(1, 0, 0, 8'h01, 0);
    step(0, 1, 0, 8'h01, 0);
    step(0, 0, 0, 8'h00, 0);

    // Mismatch at shadow idx 1, held, then resync to 8'h04.
    step(1, 0, 0, 8'h01, 0);
    step(0, 1, 1, 8'h01, 0);
    step(0, 0, 0, 8'h04, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 8'h04, 0);
    step(0, 0, 0, 8'h04, 1);
    step(0, 0, 0, 8'h04, 0);
    step(0, 1, 1, 8'h04, 0);
    step(0, 0, 0, 8'h08, 0);

    // Multi-hot: invalid encode, error, resync refused.
    step(0, 0, 0, 8'h0C, 0);
    step(0, 0, 0, 8'h0C, 1);
    step(0, 0, 0, 8'h0C, 0);

    // Clear together with an update, then reset mid-sweep at idx 5.
    step(0, 1, 1, 8'h10, 1);
    step(0, 0, 0, 8'h20, 0);
    step(1, 0, 0, 8'h01, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 8'h01 << k, 0);
    step(1, 1, 1, 8'h20, 0);
    step(0, 0, 0, 8'h01, 0);

    // Randomized counter stream with occasional faults, resyncs, reloads and resets.
    cnt = 8'h01;
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      u  = 1'($urandom);
      o  = 1'($urandom);
      c  = ($urandom_range(0, 15) == 0);
      oh = cnt;
      if ($urandom_range(0, 19) == 0) oh = cnt ^ (8'h01 << $urandom_range(0, 7));
      step(r, u, o, oh, c);
      if (r)      cnt = 8'h01;
      else if (u) cnt = o ? (cnt << 1) : (cnt >> 1);
      if (cnt == 8'h00 && $urandom_range(0, 9) == 0) cnt = 8'h01 << $urandom_range(0, 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
